// File: rtl/dma_engine.sv
// Word-copy engine for the openMSP430 DMA master port: reads one word from the source,
// writes it to the destination, and repeats for the programmed length.
module dma_engine #(
    parameter logic DMA_PRIORITY = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dma_trans_start,
    input  logic        direction_bit,
    input  logic        int_enabled,
    input  logic [15:0] dma_p1_start_addr,
    input  logic [15:0] dma_p2_start_addr,
    input  logic [15:0] dma_transfer_len,
    input  logic        clear_int,
    output logic        dma_busy,
    output logic        int_gen,
    output logic        dma_en,
    output logic [1:0]  dma_we,
    output logic [14:0] dma_addr,
    output logic [15:0] dma_din,
    output logic        dma_priority,
    output logic        dma_wkup,
    input  logic        dma_ready,
    input  logic [15:0] dma_dout
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_REQ,
        DONE
    } state_t;

    state_t      state_q;
    logic [15:0] src_q;
    logic [15:0] dst_q;
    logic [15:0] count_q;
    logic [15:0] data_q;
    logic        int_en_q;
    logic        busy_q;
    logic        int_gen_q;
    logic        en_q;
    logic [1:0]  we_q;
    logic [14:0] addr_q;

    logic [15:0] src_d;
    logic [15:0] dst_d;
    logic [15:0] src_inc_d;

    // Bit 0 of the addresses is carried along but never reaches the bus, so odd starts act word-aligned.
    assign src_d     = direction_bit ? dma_p2_start_addr : dma_p1_start_addr;
    assign dst_d     = direction_bit ? dma_p1_start_addr : dma_p2_start_addr;
    assign src_inc_d = src_q + 16'd2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            count_q   <= '0;
            data_q    <= '0;
            int_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            int_gen_q <= 1'b0;
            en_q      <= 1'b0;
            we_q      <= 2'b00;
            addr_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dma_trans_start) begin
                        int_en_q <= int_enabled;
                        src_q    <= src_d;
                        dst_q    <= dst_d;
                        count_q  <= dma_transfer_len;
                        busy_q   <= 1'b1;
                        if (dma_transfer_len != 16'd0) begin
                            state_q <= RD_REQ;
                            en_q    <= 1'b1;
                            we_q    <= 2'b00;
                            addr_q  <= src_d[15:1];
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                RD_REQ: begin
                    if (dma_ready) begin
                        state_q <= RD_DATA;
                        en_q    <= 1'b0;
                    end
                end
                RD_DATA: begin
                    data_q  <= dma_dout;
                    state_q <= WR_REQ;
                    en_q    <= 1'b1;
                    we_q    <= 2'b11;
                    addr_q  <= dst_q[15:1];
                end
                WR_REQ: begin
                    if (dma_ready) begin
                        src_q   <= src_inc_d;
                        dst_q   <= dst_q + 16'd2;
                        count_q <= count_q - 16'd1;
                        we_q    <= 2'b00;
                        if (count_q == 16'd1) begin
                            state_q <= DONE;
                            en_q    <= 1'b0;
                        end else begin
                            state_q <= RD_REQ;
                            en_q    <= 1'b1;
                            addr_q  <= src_inc_d[15:1];
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Completion set takes precedence over a coincident clear.
            if (state_q == DONE && int_en_q) begin
                int_gen_q <= 1'b1;
            end else if (clear_int) begin
                int_gen_q <= 1'b0;
            end
        end
    end

    assign dma_busy     = busy_q;
    assign dma_wkup     = busy_q;
    assign int_gen      = int_gen_q;
    assign dma_en       = en_q;
    assign dma_we       = we_q;
    assign dma_addr     = addr_q;
    assign dma_din      = data_q;
    assign dma_priority = DMA_PRIORITY;

endmodule

// File: tb/tb_dma_engine.sv
// Scoreboard bench for dma_engine: a bus/memory model answers requests and checks each
// accepted access against the expected read/write sequence queued by the stimulus.
module tb_dma_engine;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        dma_trans_start = 1'b0;
    logic        direction_bit = 1'b0;
    logic        int_enabled = 1'b0;
    logic [15:0] dma_p1_start_addr = '0;
    logic [15:0] dma_p2_start_addr = '0;
    logic [15:0] dma_transfer_len = '0;
    logic        clear_int = 1'b0;
    logic        dma_busy;
    logic        int_gen;
    logic        dma_en;
    logic [1:0]  dma_we;
    logic [14:0] dma_addr;
    logic [15:0] dma_din;
    logic        dma_priority;
    logic        dma_wkup;
    logic        dma_ready = 1'b0;
    logic [15:0] dma_dout = 16'hDEAD;

    dma_engine #(.DMA_PRIORITY(1'b0)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .dma_trans_start   (dma_trans_start),
        .direction_bit     (direction_bit),
        .int_enabled       (int_enabled),
        .dma_p1_start_addr (dma_p1_start_addr),
        .dma_p2_start_addr (dma_p2_start_addr),
        .dma_transfer_len  (dma_transfer_len),
        .clear_int         (clear_int),
        .dma_busy          (dma_busy),
        .int_gen           (int_gen),
        .dma_en            (dma_en),
        .dma_we            (dma_we),
        .dma_addr          (dma_addr),
        .dma_din           (dma_din),
        .dma_priority      (dma_priority),
        .dma_wkup          (dma_wkup),
        .dma_ready         (dma_ready),
        .dma_dout          (dma_dout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [14:0] addr;
        logic [15:0] data;
    } busOp_t;

    busOp_t      expQ[$];
    logic [15:0] mem [0:32767];
    int          total = 0;
    int          bad = 0;
    int          busyCycles = 0;
    int          enCycles = 0;
    int          writesDone = 0;
    int          waitStates = 0;
    int          stallCnt = 0;
    logic        stalled = 1'b0;
    logic [33:0] stallSnap = '0;
    logic        rdPending = 1'b0;
    logic [14:0] rdAddr = '0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Bus slave and scoreboard monitor, evaluated on the falling edge so the DUT outputs are settled.
    always @(negedge clk) begin
        if (!reset_n) begin
            dma_ready = 1'b0;
            stallCnt  = 0;
            stalled   = 1'b0;
            rdPending = 1'b0;
            dma_dout  = 16'hDEAD;
        end else begin
            if (rdPending) begin
                dma_dout  = mem[rdAddr];
                rdPending = 1'b0;
            end else begin
                dma_dout = 16'hDEAD;
            end
            if (dma_busy) busyCycles++;
            if (dma_en) begin
                enCycles++;
                if (stalled) checkOutput("stallHold", {dma_en, dma_we, dma_addr, dma_din}, stallSnap);
                if (stallCnt < waitStates) begin
                    dma_ready = 1'b0;
                    stallCnt++;
                    stalled   = 1'b1;
                    stallSnap = {dma_en, dma_we, dma_addr, dma_din};
                end else begin
                    dma_ready = 1'b1;
                    stallCnt  = 0;
                    stalled   = 1'b0;
                    if (expQ.size() == 0) begin
                        checkOutput("unexpectedAccess", {dma_we, dma_addr}, 64'h0);
                    end else begin
                        busOp_t op;
                        op = expQ.pop_front();
                        checkOutput("accessKind", dma_we, op.wr ? 2'b11 : 2'b00);
                        checkOutput("accessAddr", dma_addr, op.addr);
                        if (op.wr) begin
                            checkOutput("writeData", dma_din, op.data);
                            mem[dma_addr] = dma_din;
                            writesDone++;
                        end else begin
                            rdPending = 1'b1;
                            rdAddr    = dma_addr;
                        end
                    end
                end
            end else begin
                dma_ready = 1'b0;
                stalled   = 1'b0;
            end
        end
    end

    // Queues the expected bus traffic, then issues a one-cycle start pulse.
    task automatic applyStimulus(input logic [15:0] p1, input logic [15:0] p2, input logic [15:0] len,
                                 input logic dir, input logic inten);
        logic [15:0] s;
        logic [15:0] d;
        for (int i = 0; i < int'(len); i++) begin
            s = (dir ? p2 : p1) + 16'(2 * i);
            d = (dir ? p1 : p2) + 16'(2 * i);
            expQ.push_back('{wr: 1'b0, addr: s[15:1], data: 16'h0});
            expQ.push_back('{wr: 1'b1, addr: d[15:1], data: mem[s[15:1]]});
        end
        @(negedge clk);
        dma_p1_start_addr = p1;
        dma_p2_start_addr = p2;
        dma_transfer_len  = len;
        direction_bit     = dir;
        int_enabled       = inten;
        busyCycles        = 0;
        dma_trans_start   = 1'b1;
        @(negedge clk);
        dma_trans_start   = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (n < 500) begin
            @(negedge clk);
            if (!dma_busy) break;
            n++;
        end
        if (n >= 500) begin
            total++;
            bad++;
            $display("[TB] FAIL idleTimeout: busy still %0b after %0d cycles", dma_busy, n);
        end
        checkOutput("queueEmpty", expQ.size(), 0);
    endtask

    task automatic runCase(input string name, input logic [15:0] p1, input logic [15:0] p2,
                           input logic [15:0] len, input logic dir, input logic inten,
                           input int expBusy, input logic expInt);
        $display("[TB] case %s", name);
        applyStimulus(p1, p2, len, dir, inten);
        waitIdle();
        checkOutput({name, "_busyCycles"}, busyCycles, expBusy);
        checkOutput({name, "_intGen"}, int_gen, expInt);
    endtask

    task automatic pulseClear();
        @(negedge clk);
        clear_int = 1'b1;
        @(negedge clk);
        clear_int = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int base;
        int n;

        repeat (3) @(negedge clk);
        checkOutput("rst_busy", dma_busy, 0);
        checkOutput("rst_intGen", int_gen, 0);
        checkOutput("rst_en", dma_en, 0);
        checkOutput("rst_we", dma_we, 0);
        checkOutput("rst_addr", dma_addr, 0);
        checkOutput("rst_din", dma_din, 0);
        checkOutput("rst_priority", dma_priority, 0);
        checkOutput("rst_wkup", dma_wkup, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        mem[15'h0100] = 16'hA1A1;
        mem[15'h0101] = 16'hB2B2;
        mem[15'h0102] = 16'hC3C3;
        runCase("basic", 16'h0200, 16'h0300, 16'd3, 1'b0, 1'b1, 10, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("intSticky", int_gen, 1);
        checkOutput("copy0", mem[15'h0180], 16'hA1A1);
        checkOutput("copy2", mem[15'h0182], 16'hC3C3);
        pulseClear();
        checkOutput("intCleared", int_gen, 0);
        pulseClear();
        checkOutput("clearWhenLow", int_gen, 0);

        mem[15'h0200] = 16'h5A5A;
        runCase("reverseOdd", 16'h0500, 16'h0401, 16'd1, 1'b1, 1'b0, 4, 1'b0);
        checkOutput("reverseData", mem[15'h0280], 16'h5A5A);

        waitStates = 2;
        mem[15'h0380] = 16'h1111;
        mem[15'h0381] = 16'h2222;
        runCase("waitStates", 16'h0700, 16'h0800, 16'd2, 1'b0, 1'b0, 15, 1'b0);
        waitStates = 0;
        checkOutput("waitData", mem[15'h0401], 16'h2222);

        base = enCycles;
        runCase("lenZero", 16'h0600, 16'h0600, 16'd0, 1'b0, 1'b1, 1, 1'b1);
        checkOutput("lenZeroNoBus", enCycles - base, 0);
        pulseClear();

        mem[15'h0480] = 16'h3333;
        mem[15'h0481] = 16'h4444;
        runCase("noIntEnable", 16'h0900, 16'h0A00, 16'd2, 1'b0, 1'b0, 7, 1'b0);

        mem[15'h7FFF] = 16'h7777;
        mem[15'h0000] = 16'h8888;
        runCase("addrWrap", 16'hFFFE, 16'h0C00, 16'd2, 1'b0, 1'b0, 7, 1'b0);
        checkOutput("wrapData", mem[15'h0601], 16'h8888);

        $display("[TB] case midStart");
        applyStimulus(16'h0200, 16'h0D00, 16'd3, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        dma_p1_start_addr = 16'h1200;
        dma_p2_start_addr = 16'h1300;
        dma_transfer_len  = 16'd5;
        int_enabled       = 1'b1;
        dma_trans_start   = 1'b1;
        @(negedge clk);
        dma_trans_start   = 1'b0;
        waitIdle();
        checkOutput("midStart_busyCycles", busyCycles, 10);
        checkOutput("midStart_intGen", int_gen, 0);

        $display("[TB] case clearAtDone");
        mem[15'h0500] = 16'h9999;
        applyStimulus(16'h0A00, 16'h0B00, 16'd1, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("doneCycle", {dma_busy, dma_en}, 2'b10);
        clear_int = 1'b1;
        @(negedge clk);
        clear_int = 1'b0;
        checkOutput("setWinsOverClear", int_gen, 1);
        waitIdle();

        $display("[TB] case resetMidTransfer");
        mem[15'h0800] = 16'hC001;
        mem[15'h0801] = 16'hC002;
        mem[15'h0802] = 16'hC003;
        mem[15'h0803] = 16'hC004;
        base = writesDone;
        applyStimulus(16'h1000, 16'h1100, 16'd4, 1'b0, 1'b1);
        n = 0;
        while (n < 100 && !(writesDone - base == 2 && dma_en && dma_we == 2'b11)) begin
            @(negedge clk);
            #2;
            n++;
        end
        checkOutput("reachedWord2Write", n < 100, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("asyncRst_en", dma_en, 0);
        checkOutput("asyncRst_busy", dma_busy, 0);
        checkOutput("asyncRst_intGen", int_gen, 0);
        repeat (2) @(negedge clk);
        expQ.delete();
        reset_n = 1'b1;
        base = enCycles;
        repeat (5) @(negedge clk);
        checkOutput("postRst_idleBusy", dma_busy, 0);
        checkOutput("postRst_noBus", enCycles - base, 0);

        mem[15'h0880] = 16'hBEEF;
        runCase("afterReset", 16'h1100, 16'h1200, 16'd1, 1'b0, 1'b1, 4, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
